// File: rtl/rom_burst_reader.sv
// Burst read sequencer in front of a 2-cycle synchronous ROM: one credit-limited read per cycle,
// tagged responses captured into a show-ahead FIFO and streamed out valid/ready with a last marker.
module rom_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK_I,
  input  logic                  RSTN_I,
  input  logic                  START_I,
  input  logic [ADDR_WIDTH-1:0] BASE_ADDR_I,
  input  logic [LEN_WIDTH-1:0]  LEN_I,
  output logic                  BUSY_O,
  output logic                  DONE_O,
  output logic                  ERR_O,
  output logic                  ROM_RE_O,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR_O,
  input  logic [DATA_WIDTH-1:0] ROM_DATA_I,
  input  logic [ADDR_WIDTH-1:0] ROM_ADDR_I,
  output logic [DATA_WIDTH-1:0] M_DATA_O,
  output logic [ADDR_WIDTH-1:0] M_ADDR_O,
  output logic                  M_VALID_O,
  input  logic                  M_READY_I,
  output logic                  M_LAST_O
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam int ENT_W = DATA_WIDTH + ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  issue_cnt_q;
  logic [LEN_WIDTH-1:0]  beat_cnt_q;
  logic                  done_q;
  logic                  err_q;
  logic                  s1_vld_q;
  logic                  s2_vld_q;
  logic [ADDR_WIDTH-1:0] s1_tag_q;
  logic [ADDR_WIDTH-1:0] s2_tag_q;
  logic [ENT_W-1:0]      fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [SUM_W-1:0]      credit_sum;
  logic                  issue;
  logic                  push;
  logic                  pop;

  // Every outstanding read already owns a FIFO slot, so a push can never find the FIFO full.
  assign credit_sum = SUM_W'(cnt_q) + SUM_W'(s1_vld_q) + SUM_W'(s2_vld_q);
  assign issue      = (state_q == ISSUE) && (credit_sum < SUM_W'(FIFO_DEPTH));
  assign push       = s2_vld_q;
  assign pop        = M_VALID_O && M_READY_I;

  assign M_VALID_O              = (cnt_q != '0);
  assign {M_DATA_O, M_ADDR_O}   = fifo_q[rd_ptr_q];
  assign M_LAST_O               = M_VALID_O && (beat_cnt_q == LEN_WIDTH'(1));
  assign BUSY_O                 = (state_q != IDLE);
  assign DONE_O                 = done_q;
  assign ERR_O                  = err_q;
  assign ROM_RE_O               = issue;
  assign ROM_ADDR_O             = addr_q;

  always_ff @(posedge CLK_I) begin
    if (!RSTN_I) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s1_tag_q    <= '0;
      s2_tag_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START_I) begin
            if (LEN_I != '0) begin
              addr_q      <= BASE_ADDR_I;
              issue_cnt_q <= LEN_I;
              beat_cnt_q  <= LEN_I;
              err_q       <= 1'b0;
              state_q     <= ISSUE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            addr_q      <= addr_q + ADDR_WIDTH'(1);
            issue_cnt_q <= issue_cnt_q - LEN_WIDTH'(1);
            if (issue_cnt_q == LEN_WIDTH'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: ;
        default: state_q <= IDLE;
      endcase

      if (pop) begin
        beat_cnt_q <= beat_cnt_q - LEN_WIDTH'(1);
        if (beat_cnt_q == LEN_WIDTH'(1)) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
      end

      // Tag pipeline lines up with the ROM's two register stages.
      s1_vld_q <= issue;
      s1_tag_q <= addr_q;
      s2_vld_q <= s1_vld_q;
      s2_tag_q <= s1_tag_q;
      if (s2_vld_q && (ROM_ADDR_I != s2_tag_q)) err_q <= 1'b1;

      if (push) begin
        fifo_q[wr_ptr_q] <= {ROM_DATA_I, ROM_ADDR_I};
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Scoreboarded bench for rom_burst_reader with a 2-cycle ROM model and randomized bursts/back-pressure.
module tb_rom_burst_reader;

  logic       CLK_I = 1'b0;
  logic       RSTN_I;
  logic       START_I;
  logic [7:0] BASE_ADDR_I;
  logic [8:0] LEN_I;
  logic       BUSY_O, DONE_O, ERR_O, ROM_RE_O;
  logic [7:0] ROM_ADDR_O, ROM_DATA_I, ROM_ADDR_I;
  logic [7:0] M_DATA_O, M_ADDR_O;
  logic       M_VALID_O, M_READY_I, M_LAST_O;

  always #5 CLK_I = ~CLK_I;

  rom_burst_reader dut (
    .CLK_I(CLK_I), .RSTN_I(RSTN_I), .START_I(START_I), .BASE_ADDR_I(BASE_ADDR_I), .LEN_I(LEN_I),
    .BUSY_O(BUSY_O), .DONE_O(DONE_O), .ERR_O(ERR_O), .ROM_RE_O(ROM_RE_O), .ROM_ADDR_O(ROM_ADDR_O),
    .ROM_DATA_I(ROM_DATA_I), .ROM_ADDR_I(ROM_ADDR_I), .M_DATA_O(M_DATA_O), .M_ADDR_O(M_ADDR_O),
    .M_VALID_O(M_VALID_O), .M_READY_I(M_READY_I), .M_LAST_O(M_LAST_O)
  );

  // ROM model: address register on RE, then output register.
  logic [7:0] rom_mem [256];
  logic [7:0] a1 = 8'h00, a2 = 8'h00;
  logic       corrupt_en = 1'b0;
  logic [7:0] corrupt_a  = 8'h00;
  always @(posedge CLK_I) begin
    if (ROM_RE_O) a1 <= ROM_ADDR_O;
    a2 <= a1;
  end
  assign ROM_DATA_I = rom_mem[a2];
  assign ROM_ADDR_I = (corrupt_en && a2 == corrupt_a) ? ~a2 : a2;

  typedef struct { logic [7:0] d; logic [7:0] a; logic l; } exp_t;
  exp_t expq[$];
  exp_t e;

  int tests = 0, fails = 0, cyc = 0;
  int issued = 0, popped = 0, done_cnt = 0, done_cyc = 0, ready_mode = 0;
  logic       held_vld = 1'b0, held_l;
  logic [7:0] held_d, held_a;

  always @(posedge CLK_I) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pops, credit rule, stall stability, DONE bookkeeping.
  always @(negedge CLK_I) begin
    if (!RSTN_I) begin
      issued   = 0;
      popped   = 0;
      held_vld = 1'b0;
    end else begin
      if (held_vld && M_VALID_O) begin
        chk("stall_data", 32'(M_DATA_O), 32'(held_d));
        chk("stall_addr", 32'(M_ADDR_O), 32'(held_a));
        chk("stall_last", 32'(M_LAST_O), 32'(held_l));
      end
      if (ROM_RE_O) begin
        chk("credit", 32'(issued - popped < 4), 32'd1);
        issued++;
      end
      if (M_VALID_O && M_READY_I) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got addr 0x%0h data 0x%0h, want no beat (cycle %0d)",
                   M_ADDR_O, M_DATA_O, cyc);
        end else begin
          e = expq.pop_front();
          chk("beat_data", 32'(M_DATA_O), 32'(e.d));
          chk("beat_addr", 32'(M_ADDR_O), 32'(e.a));
          chk("beat_last", 32'(M_LAST_O), 32'(e.l));
        end
        popped++;
      end
      if (DONE_O) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", 32'(BUSY_O), 32'd0);
      end
      held_vld = M_VALID_O && !M_READY_I;
      held_d   = M_DATA_O;
      held_a   = M_ADDR_O;
      held_l   = M_LAST_O;
    end
  end

  initial begin
    M_READY_I = 1'b1;
    forever begin
      @(posedge CLK_I);
      #1;
      case (ready_mode)
        0:       M_READY_I = 1'b1;
        1:       M_READY_I = (cyc % 3 == 0);
        default: M_READY_I = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      logic [7:0] a, ea;
      a  = base + 8'(i);
      ea = (corrupt_en && a == corrupt_a) ? ~a : a;
      expq.push_back('{rom_mem[a], ea, (i == len - 1)});
    end
  endtask

  task automatic start_burst(input logic [7:0] base, input int len, output int s);
    START_I     = 1'b1;
    BASE_ADDR_I = base;
    LEN_I       = 9'(len);
    s           = cyc;
    push_exp(base, len);
    tick();
    START_I = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string nm);
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin
      tick();
      n++;
    end
    if (done_cnt == d0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no DONE_O, want DONE_O within 3000 cycles", nm);
    end
    chk({nm, "_queue_empty"}, 32'(expq.size()), 32'd0);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_busy"},  32'(BUSY_O),     32'd0);
    chk({nm, "_done"},  32'(DONE_O),     32'd0);
    chk({nm, "_err"},   32'(ERR_O),      32'd0);
    chk({nm, "_re"},    32'(ROM_RE_O),   32'd0);
    chk({nm, "_raddr"}, 32'(ROM_ADDR_O), 32'd0);
    chk({nm, "_valid"}, 32'(M_VALID_O),  32'd0);
    chk({nm, "_last"},  32'(M_LAST_O),   32'd0);
    chk({nm, "_mdata"}, 32'(M_DATA_O),   32'd0);
    chk({nm, "_maddr"}, 32'(M_ADDR_O),   32'd0);
  endtask

  // Cycle-exact burst with ready held high: reads s+1..s+N, beats s+4..s+N+3, DONE at s+N+4.
  task automatic timed_burst(input logic [7:0] base, input int len, input string nm);
    int s;
    int d0 = done_cnt;
    start_burst(base, len, s);
    for (int k = 1; k <= len + 4; k++) begin
      chk({nm, "_re"},    32'(ROM_RE_O),  32'(k <= len));
      chk({nm, "_valid"}, 32'(M_VALID_O), 32'(k >= 4 && k <= len + 3));
      chk({nm, "_last"},  32'(M_LAST_O),  32'(k == len + 3));
      chk({nm, "_done"},  32'(DONE_O),    32'(k == len + 4));
      chk({nm, "_busy"},  32'(BUSY_O),    32'(k < len + 4));
      if (k < len + 4) tick();
    end
    wait_done(d0, nm);
    chk({nm, "_done_cyc"}, 32'(done_cyc), 32'(s + len + 4));
    chk({nm, "_err"}, 32'(ERR_O), 32'd0);
  endtask

  initial begin
    int s, d0, i0;
    #600000;
    $display("FAIL watchdog: simulation still running at 600000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, d0, i0;
    RSTN_I = 1'b0;
    START_I = 1'b0;
    BASE_ADDR_I = 8'h00;
    LEN_I = 9'd0;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i);
    repeat (2) tick();
    chk_reset("por");
    RSTN_I = 1'b1;
    tick();

    timed_burst(8'h10, 4, "basic");
    timed_burst(8'hFE, 4, "wrap");

    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);

    ready_mode = 1;
    d0 = done_cnt;
    start_burst(8'h30, 16, s);
    wait_done(d0, "bp16");
    ready_mode = 0;

    i0 = issued;
    d0 = done_cnt;
    start_burst(8'h55, 0, s);
    chk("len0_done", 32'(DONE_O), 32'd1);
    chk("len0_busy", 32'(BUSY_O), 32'd0);
    tick();
    chk("len0_done_pulse", 32'(DONE_O), 32'd0);
    chk("len0_no_reads", 32'(issued), 32'(i0));
    chk("len0_done_cnt", 32'(done_cnt), 32'(d0 + 1));

    d0 = done_cnt;
    start_burst(8'h40, 8, s);
    tick();
    tick();
    START_I = 1'b1;
    BASE_ADDR_I = 8'h80;
    LEN_I = 9'd5;
    tick();
    START_I = 1'b0;
    wait_done(d0, "midstart");
    repeat (6) tick();
    chk("midstart_done_cnt", 32'(done_cnt), 32'(d0 + 1));
    chk("midstart_busy", 32'(BUSY_O), 32'd0);

    start_burst(8'h20, 8, s);
    repeat (3) tick();
    RSTN_I = 1'b0;
    expq.delete();
    tick();
    RSTN_I = 1'b1;
    chk_reset("midrst");
    repeat (8) tick();
    chk("midrst_no_reads", 32'(issued), 32'd0);
    chk("midrst_idle", 32'(BUSY_O), 32'd0);
    timed_burst(8'h70, 5, "postrst");

    ready_mode = 2;
    corrupt_en = 1'b1;
    corrupt_a = 8'h92;
    d0 = done_cnt;
    start_burst(8'h90, 6, s);
    wait_done(d0, "corrupt");
    chk("err_set", 32'(ERR_O), 32'd1);
    repeat (3) tick();
    chk("err_sticky", 32'(ERR_O), 32'd1);
    corrupt_en = 1'b0;
    d0 = done_cnt;
    start_burst(8'h10, 3, s);
    chk("err_cleared", 32'(ERR_O), 32'd0);
    wait_done(d0, "after_err");

    for (int n = 0; n < 12; n++) begin
      ready_mode = $urandom_range(0, 2);
      if (n % 4 == 0) for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
      d0 = done_cnt;
      start_burst(8'($urandom), $urandom_range(1, 40), s);
      wait_done(d0, "rand");
      chk("rand_err", 32'(ERR_O), 32'd0);
    end

    ready_mode = 2;
    d0 = done_cnt;
    start_burst(8'hC3, 256, s);
    wait_done(d0, "maxlen");
    chk("maxlen_err", 32'(ERR_O), 32'd0);

    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
